clock_core_gen2: RTL and testbench
==================================

# clock_core_gen2

Parametrised timekeeping core: the next generation of the time register and display-update sequencer. It adds selectable 12/24-hour mode, an alarm with auto-timeout, and a level-held display request handshake with pending-update coalescing. It sits between the strobe generator and debounced buttons on the input side, and the MAX7219 output wrapper on the output side.

## Interface
- TWELVE_HOUR, default 0: 1 selects 12-hour mode (hours 1..12 plus o_pm); 0 selects 24-hour mode (hours 0..23).
- ALARM_TIMEOUT_S, default 60: seconds an alarm stays active before it auto-clears (range 1..255).
- i_clk  in  1  system clock (~50 MHz).
- i_reset  in  1  reset; asynchronous, active-high.
- i_1hz_stb  in  1  one-cycle timebase tick.
- i_set_stb  in  1  one-cycle set-rate tick (fast or slow, selected upstream).
- i_set_hours  in  1  debounced; advance hours on each i_set_stb.
- i_set_minutes  in  1  debounced; advance minutes on each i_set_stb.
- i_set_alarm  in  1  set actions target the alarm registers instead of the time.
- i_alarm_en  in  1  arms alarm matching.
- i_alarm_clear  in  1  clears an active alarm.
- i_display_ack  in  1  output wrapper has accepted the current request.
- o_hours  out  5  current hours.
- o_minutes  out  6  current minutes.
- o_seconds  out  6  current seconds.
- o_pm  out  1  PM flag; always 0 when TWELVE_HOUR=0.
- o_alarm_hours  out  5  alarm hours.
- o_alarm_minutes  out  6  alarm minutes.
- o_alarm_active  out  1  alarm is ringing.
- o_display_stb  out  1  display update request, level-held.
- o_write_config  out  1  qualifies the request as a configuration write.

## Operation
- Reset values:
  - Time is 00:00:00 in 24-hour mode, or 12:00:00 with o_pm=0 in 12-hour mode.
  - Alarm registers take the same hour/minute values.
  - o_alarm_active=0.
  - o_display_stb=1 and o_write_config=1, because the FSM enters CONFIG.
- Run mode (i_set_hours=i_set_minutes=0):
  - On i_1hz_stb: seconds count 59→0 with carry into minutes; minutes count 59→0 with carry into hours.
  - 24-hour: hours count 23→0.
  - 12-hour: hours count 12→1; the 11→12 step toggles o_pm.
- Set mode (either set input high):
  - i_1hz_stb is ignored for the target registers.
  - Each i_set_stb advances the selected field(s) by 1 with wrap and no carry.
  - Setting the time also forces seconds to 0.
  - Both set inputs high means both fields advance on the same strobe.
- With i_set_alarm=1, set actions apply to the alarm registers only. Time keeps running on i_1hz_stb.
- Alarm trigger: on the tick that makes seconds 0, o_alarm_active sets if i_alarm_en=1 and the new hours/minutes (and o_pm in 12-hour mode) equal the alarm registers.
- Alarm clear:
  - An 8-bit timeout counter loads ALARM_TIMEOUT_S on trigger and decrements on each i_1hz_stb; o_alarm_active clears at 0.
  - i_alarm_clear=1 or i_alarm_en=0 clears it immediately.
  - If clear and trigger occur in the same cycle, clear wins.
- Display FSM states: CONFIG, IDLE, REQ.
  - CONFIG: o_display_stb=1 and o_write_config=1; on ack, go to IDLE.
  - IDLE: on any update event, go to REQ.
  - REQ: o_display_stb=1 and o_write_config=0; on ack, go to IDLE, or back to REQ if a pending event is held.
- Update events: any change of a time or alarm register, or any change of o_alarm_active.
- An event during CONFIG or REQ sets a single pending flag, so multiple events coalesce into one request. Pending is cleared on entry to REQ.

## Timing
- Register update happens on the edge that samples the strobe, so outputs change 1 cycle after the strobe.
- o_display_stb rises on the same edge as the register update (IDLE→REQ).
- Handshake:
  - o_display_stb stays high until i_display_ack is sampled high.
  - It drops on the following edge when no event is pending.
  - It remains high with no low cycle when pending, or when a new event coincides with the ack.
  - i_display_ack in IDLE is ignored.
- Reset asserted mid-request immediately returns all state to reset values and the FSM to CONFIG. The pending flag is cleared.

## Structure
- Package clock_pkg holds:
  - SEC_MAX=59, MIN_MAX=59, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12.
  - Field widths 6/6/5.
  - Display FSM state enum {CONFIG, IDLE, REQ}.
- One sub-module, wrap_counter: a parametrised MIN/MAX counter with inc enable, force-to-MIN, and a wrap-carry output. It is used for seconds, minutes, and both alarm fields. Hours use custom logic for the 12-hour/PM handling.

## Test plan
- Reset, then ack after 3 cycles → o_write_config=1 until the ack; then IDLE with time 00:00:00 (12:00:00 AM when TWELVE_HOUR=1).
- Preload 23:59:59 in 24-hour mode, one i_1hz_stb → 00:00:00, with exactly one o_display_stb request.
- TWELVE_HOUR=1: preload 11:59:59 AM, tick → 12:00:00 with o_pm=1; preload 12:59:59 PM, tick → 01:00:00 with o_pm=1.
- i_set_minutes=1 at time 10:59:30, one i_set_stb → 10:00:00 (no carry into hours, seconds zeroed); the same with i_set_alarm=1 changes only the alarm minutes while seconds keep counting.
- Alarm set to 07:00 with i_alarm_en=1, time ticks 06:59:59→07:00:00 → o_alarm_active=1; after 60 more ticks it is 0; a separate run with i_alarm_clear in the trigger cycle keeps it at 0.
- Hold ack low while issuing 3 ticks → o_display_stb stays high; first ack → one extra request, then IDLE (coalescing).

Source files
------------

// File: rtl/clock_pkg.sv
// Shared limits, field widths and display FSM encoding
// for the clock_core_gen2 timekeeping slice.
package clock_pkg;

  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HR_W     = 5;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MIN = 1;
  localparam int HR12_MAX = 12;

  typedef enum logic [1:0] {
    CONFIG,
    IDLE,
    REQ
  } disp_state_t;

  function automatic logic [HR_W-1:0] hr_next(
    input logic [HR_W-1:0] h,
    input logic            twelve
  );
    if (twelve)
      return (h == HR_W'(HR12_MAX)) ? HR_W'(HR12_MIN) : h + 1'b1;
    else
      return (h == HR_W'(HR24_MAX)) ? '0 : h + 1'b1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// MIN..MAX counter with increment, force-to-MIN and wrap carry.
// Exposes its next value so the parent can compare ahead of the edge.
module wrap_counter #(
  parameter int W   = 6,
  parameter int MIN = 0,
  parameter int MAX = 59,
  parameter int RST = MIN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  assign wrap = inc && (q == W'(MAX));

  always_comb begin
    nxt = q;
    if (clr)
      nxt = W'(MIN);
    else if (inc)
      nxt = wrap ? W'(MIN) : q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= W'(RST);
    else     q <= nxt;
  end

endmodule

// File: rtl/clock_core_gen2.sv
// Time/alarm registers with 12/24h mode, alarm timeout and a
// level-held display request handshake with update coalescing.
module clock_core_gen2
  import clock_pkg::*;
#(
  parameter bit TWELVE_HOUR     = 1'b0,
  parameter int ALARM_TIMEOUT_S = 60
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_1hz_stb,
  input  logic             i_set_stb,
  input  logic             i_set_hours,
  input  logic             i_set_minutes,
  input  logic             i_set_alarm,
  input  logic             i_alarm_en,
  input  logic             i_alarm_clear,
  input  logic             i_display_ack,
  output logic [HR_W-1:0]  o_hours,
  output logic [MIN_W-1:0] o_minutes,
  output logic [SEC_W-1:0] o_seconds,
  output logic             o_pm,
  output logic [HR_W-1:0]  o_alarm_hours,
  output logic [MIN_W-1:0] o_alarm_minutes,
  output logic             o_alarm_active,
  output logic             o_display_stb,
  output logic             o_write_config
);

  localparam logic [HR_W-1:0] HR_RST =
    TWELVE_HOUR ? HR_W'(HR12_MAX) : '0;
  localparam int AH_MIN = TWELVE_HOUR ? HR12_MIN : 0;
  localparam int AH_MAX = TWELVE_HOUR ? HR12_MAX : HR24_MAX;
  localparam int AH_RST = TWELVE_HOUR ? HR12_MAX : 0;

  logic set_any, time_set, tick, set_t, set_a;
  logic sec_wrap, min_wrap, am_wrap, ah_wrap;
  logic min_inc, hr_inc, am_inc, ah_inc;
  logic [SEC_W-1:0] sec, sec_nxt;
  logic [MIN_W-1:0] mins, min_nxt, a_min, am_nxt;
  logic [HR_W-1:0]  hours, hr_nxt, a_hr, ah_nxt;
  logic pm, pm_nxt, a_pm, apm_nxt;
  logic act, act_nxt, trig, evt, pend;
  logic [7:0] cnt, cnt_nxt;
  logic stb, cfg;
  disp_state_t state;
  logic unused;

  assign set_any  = i_set_hours | i_set_minutes;
  assign time_set = set_any & ~i_set_alarm;
  assign tick     = i_1hz_stb & ~time_set;
  assign set_t    = i_set_stb & time_set;
  assign set_a    = i_set_stb & i_set_alarm & set_any;

  assign min_inc = (tick & sec_wrap) | (set_t & i_set_minutes);
  assign hr_inc  = (tick & sec_wrap & min_wrap) | (set_t & i_set_hours);
  assign am_inc  = set_a & i_set_minutes;
  assign ah_inc  = set_a & i_set_hours;

  wrap_counter #(.W(SEC_W), .MIN(0), .MAX(SEC_MAX)) u_sec (
    .clk(i_clk), .rst(i_reset), .inc(tick), .clr(set_t),
    .q(sec), .nxt(sec_nxt), .wrap(sec_wrap)
  );

  wrap_counter #(.W(MIN_W), .MIN(0), .MAX(MIN_MAX)) u_min (
    .clk(i_clk), .rst(i_reset), .inc(min_inc), .clr(1'b0),
    .q(mins), .nxt(min_nxt), .wrap(min_wrap)
  );

  wrap_counter #(.W(MIN_W), .MIN(0), .MAX(MIN_MAX)) u_amin (
    .clk(i_clk), .rst(i_reset), .inc(am_inc), .clr(1'b0),
    .q(a_min), .nxt(am_nxt), .wrap(am_wrap)
  );

  wrap_counter #(
    .W(HR_W), .MIN(AH_MIN), .MAX(AH_MAX), .RST(AH_RST)
  ) u_ahr (
    .clk(i_clk), .rst(i_reset), .inc(ah_inc), .clr(1'b0),
    .q(a_hr), .nxt(ah_nxt), .wrap(ah_wrap)
  );

  assign unused = am_wrap ^ ah_wrap;

  // PM flips on the 11 -> 12 step, both for time and alarm
  assign hr_nxt  = hr_inc ? hr_next(hours, TWELVE_HOUR) : hours;
  assign pm_nxt  = pm ^ (TWELVE_HOUR && hr_inc &&
                         hours == HR_W'(11));
  assign apm_nxt = a_pm ^ (TWELVE_HOUR && ah_inc &&
                           a_hr == HR_W'(11));

  assign trig = tick & sec_wrap & i_alarm_en &
                (hr_nxt == a_hr) & (min_nxt == a_min) &
                (pm_nxt == a_pm);

  always_comb begin
    act_nxt = act;
    cnt_nxt = cnt;
    if (i_alarm_clear || !i_alarm_en) begin
      act_nxt = 1'b0;
      cnt_nxt = '0;
    end else if (trig) begin
      act_nxt = 1'b1;
      cnt_nxt = 8'(ALARM_TIMEOUT_S);
    end else if (act && i_1hz_stb) begin
      cnt_nxt = cnt - 8'd1;
      if (cnt == 8'd1) act_nxt = 1'b0;
    end
  end

  assign evt = (sec_nxt != sec) | (min_nxt != mins) |
               (hr_nxt != hours) | (pm_nxt != pm) |
               (am_nxt != a_min) | (ah_nxt != a_hr) |
               (apm_nxt != a_pm) | (act_nxt != act);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hours <= HR_RST;
      pm    <= 1'b0;
      a_pm  <= 1'b0;
      act   <= 1'b0;
      cnt   <= '0;
      state <= CONFIG;
      pend  <= 1'b0;
      stb   <= 1'b1;
      cfg   <= 1'b1;
    end else begin
      hours <= hr_nxt;
      pm    <= pm_nxt;
      a_pm  <= apm_nxt;
      act   <= act_nxt;
      cnt   <= cnt_nxt;
      unique case (state)
        CONFIG: begin
          pend <= pend | evt;
          if (i_display_ack) begin
            state <= IDLE;
            stb   <= 1'b0;
            cfg   <= 1'b0;
          end
        end
        IDLE: begin
          if (evt || pend) begin
            state <= REQ;
            stb   <= 1'b1;
            cfg   <= 1'b0;
            pend  <= 1'b0;
          end
        end
        REQ: begin
          if (i_display_ack && (pend || evt)) begin
            pend <= 1'b0;
          end else if (i_display_ack) begin
            state <= IDLE;
            stb   <= 1'b0;
          end else begin
            pend <= pend | evt;
          end
        end
        default: begin
          state <= CONFIG;
          stb   <= 1'b1;
          cfg   <= 1'b1;
        end
      endcase
    end
  end

  assign o_hours         = hours;
  assign o_minutes       = mins;
  assign o_seconds       = sec;
  assign o_pm            = pm;
  assign o_alarm_hours   = a_hr;
  assign o_alarm_minutes = a_min;
  assign o_alarm_active  = act;
  assign o_display_stb   = stb;
  assign o_write_config  = cfg;

endmodule

// File: tb/tb_clock_core_gen2.sv
// Bench: 24h and 12h instances on shared stimulus, checked against
// a seconds-of-day / minutes-of-day reference model.
module tb_clock_core_gen2;

  localparam int TO = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic one_hz = 0, set_stb = 0, set_h = 0, set_m = 0, set_a = 0;
  logic en = 0, aclr = 0, ack = 0;

  logic [4:0] h24, ah24, h12, ah12;
  logic [5:0] m24, s24, am24, m12, s12, am12;
  logic pm24, act24, stb24, cfg24, pm12, act12, stb12, cfg12;

  int t, al, acnt;
  bit act;
  int vec, miss;
  bit auto_ack;

  always #5 clk = ~clk;

  clock_core_gen2 #(.TWELVE_HOUR(1'b0), .ALARM_TIMEOUT_S(TO)) u24 (
    .i_clk(clk), .i_reset(rst), .i_1hz_stb(one_hz),
    .i_set_stb(set_stb), .i_set_hours(set_h),
    .i_set_minutes(set_m), .i_set_alarm(set_a),
    .i_alarm_en(en), .i_alarm_clear(aclr),
    .i_display_ack(ack), .o_hours(h24), .o_minutes(m24),
    .o_seconds(s24), .o_pm(pm24), .o_alarm_hours(ah24),
    .o_alarm_minutes(am24), .o_alarm_active(act24),
    .o_display_stb(stb24), .o_write_config(cfg24)
  );

  clock_core_gen2 #(.TWELVE_HOUR(1'b1), .ALARM_TIMEOUT_S(TO)) u12 (
    .i_clk(clk), .i_reset(rst), .i_1hz_stb(one_hz),
    .i_set_stb(set_stb), .i_set_hours(set_h),
    .i_set_minutes(set_m), .i_set_alarm(set_a),
    .i_alarm_en(en), .i_alarm_clear(aclr),
    .i_display_ack(ack), .o_hours(h12), .o_minutes(m12),
    .o_seconds(s12), .o_pm(pm12), .o_alarm_hours(ah12),
    .o_alarm_minutes(am12), .o_alarm_active(act12),
    .o_display_stb(stb12), .o_write_config(cfg12)
  );

  logic [59:0] obs;
  logic [3:0]  hs;
  assign obs = {h24, m24, s24, pm24, ah24, am24, act24,
                h12, m12, s12, pm12, ah12, am12, act12};
  assign hs  = {stb24, cfg24, stb12, cfg12};

  function automatic logic [29:0] expv(bit tw);
    int h, ah;
    logic [4:0] hh, ahh;
    h  = t / 3600;
    ah = al / 60;
    hh  = tw ? 5'((h % 12 == 0) ? 12 : h % 12) : 5'(h);
    ahh = tw ? 5'((ah % 12 == 0) ? 12 : ah % 12) : 5'(ah);
    return {hh, 6'((t / 60) % 60), 6'(t % 60),
            logic'(tw && h >= 12), ahh, 6'(al % 60), logic'(act)};
  endfunction

  function automatic logic [59:0] expo();
    return {expv(1'b0), expv(1'b1)};
  endfunction

  task automatic model_reset();
    t = 0; al = 0; act = 0; acnt = 0;
  endtask

  task automatic model_step();
    bit tset, tk, trig;
    int h, m;
    tset = (set_h | set_m) & !set_a;
    tk   = one_hz & !tset;
    trig = 0;
    if (tset && set_stb) begin
      h = t / 3600; m = (t / 60) % 60;
      if (set_h) h = (h + 1) % 24;
      if (set_m) m = (m + 1) % 60;
      t = h * 3600 + m * 60;
    end
    if (tk) begin
      t = (t + 1) % 86400;
      trig = (t % 60 == 0) && en && (t / 60 == al);
    end
    if (set_a && (set_h || set_m) && set_stb) begin
      h = al / 60; m = al % 60;
      if (set_h) h = (h + 1) % 24;
      if (set_m) m = (m + 1) % 60;
      al = h * 60 + m;
    end
    if (aclr || !en) begin
      act = 0; acnt = 0;
    end else if (trig) begin
      act = 1; acnt = TO;
    end else if (act && one_hz) begin
      acnt--;
      if (acnt == 0) act = 0;
    end
  endtask

  task automatic step();
    if (auto_ack) ack = stb24;
    model_step();
    @(posedge clk); #1;
    one_hz = 0; set_stb = 0; ack = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    auto_ack = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (!stb24 && !stb12) done = 1;
    end
    auto_ack = 0;
    vec++;
    if (!done) begin
      miss++;
      $display("FAIL drain: stb %b still high, required 0", hs);
    end
  endtask

  task automatic goto(int hh, int mm, int ss);
    int n;
    auto_ack = 1;
    set_a = 0; set_m = 0; set_h = 1;
    n = (hh - t / 3600 + 24) % 24;
    if (n == 0) n = 24;
    repeat (n) begin set_stb = 1; step(); end
    set_h = 0; set_m = 1;
    n = (mm - (t / 60) % 60 + 60) % 60;
    repeat (n) begin set_stb = 1; step(); end
    set_m = 0;
    repeat (ss) begin one_hz = 1; step(); end
    auto_ack = 0;
  endtask

  task automatic goto_alarm(int hh, int mm);
    int n;
    auto_ack = 1;
    set_a = 1; set_m = 0; set_h = 1;
    n = (hh - al / 60 + 24) % 24;
    repeat (n) begin set_stb = 1; step(); end
    set_h = 0; set_m = 1;
    n = (mm - al % 60 + 60) % 60;
    repeat (n) begin set_stb = 1; step(); end
    set_m = 0; set_a = 0;
    auto_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (obs !== expo()) begin
      miss++; $display("FAIL reset_regs: got %h want %h", obs, expo());
    end
    vec++;
    if (hs !== 4'b1111) begin
      miss++; $display("FAIL reset_cfg: got %b want 1111", hs);
    end
    rst = 0;
    repeat (3) step();
    vec++;
    if (hs !== 4'b1111) begin
      miss++; $display("FAIL cfg_hold: got %b want 1111", hs);
    end
    ack = 1; step();
    vec++;
    if (hs !== 4'b0000) begin
      miss++; $display("FAIL cfg_ack: got %b want 0000", hs);
    end
    step();
    vec++;
    if ({obs, hs} !== {expo(), 4'b0000}) begin
      miss++; $display("FAIL idle_time: got %h/%b want %h/0000", obs, hs, expo());
    end
  endtask

  task automatic test_rollover();
    int hi;
    goto(23, 59, 59);
    drain();
    vec++;
    if (obs !== expo()) begin
      miss++; $display("FAIL preload_2359: got %h want %h", obs, expo());
    end
    one_hz = 1; step();
    vec++;
    if ({obs, hs} !== {expo(), 4'b1010}) begin
      miss++; $display("FAIL rollover: got %h/%b want %h/1010", obs, hs, expo());
    end
    ack = 1; step();
    hi = 0;
    repeat (4) begin
      if (stb24 || stb12) hi++;
      step();
    end
    vec++;
    if (hi !== 0) begin
      miss++; $display("FAIL roll_single: extra stb cycles %0d want 0", hi);
    end
  endtask

  task automatic test_twelve();
    int pt[3];
    pt = '{11, 12, 23};
    foreach (pt[i]) begin
      goto(pt[i], 59, 59);
      drain();
      one_hz = 1; step();
      vec++;
      if (obs !== expo()) begin
        miss++; $display("FAIL hour_step_%0d: got %h want %h", pt[i], obs, expo());
      end
      drain();
    end
  endtask

  task automatic test_set();
    goto(10, 59, 30);
    drain();
    set_m = 1; set_stb = 1; step();
    set_m = 0;
    vec++;
    if (obs !== expo()) begin
      miss++; $display("FAIL set_min_nocarry: got %h want %h", obs, expo());
    end
    set_a = 1; set_m = 1; set_stb = 1; one_hz = 1; step();
    vec++;
    if (obs !== expo()) begin
      miss++; $display("FAIL set_alarm_min: got %h want %h", obs, expo());
    end
    one_hz = 1; step();
    set_a = 0; set_m = 0;
    vec++;
    if (obs !== expo()) begin
      miss++; $display("FAIL alarm_run: got %h want %h", obs, expo());
    end
    set_h = 1; set_m = 1; set_stb = 1; step();
    set_h = 0; set_m = 0;
    vec++;
    if (obs !== expo()) begin
      miss++; $display("FAIL set_both: got %h want %h", obs, expo());
    end
    drain();
  endtask

  task automatic test_alarm();
    en = 0;
    goto_alarm(7, 0);
    goto(6, 59, 59);
    en = 1;
    drain();
    auto_ack = 1;
    one_hz = 1; step();
    vec++;
    if ({obs, act24} !== {expo(), 1'b1}) begin
      miss++; $display("FAIL alarm_trig: got %h want %h", obs, expo());
    end
    repeat (59) begin one_hz = 1; step(); end
    vec++;
    if ({obs, act12} !== {expo(), 1'b1}) begin
      miss++; $display("FAIL alarm_hold: got %h want %h", obs, expo());
    end
    one_hz = 1; step();
    vec++;
    if ({obs, act24} !== {expo(), 1'b0}) begin
      miss++; $display("FAIL alarm_timeout: got %h want %h", obs, expo());
    end
    goto(6, 59, 59);
    aclr = 1; one_hz = 1; step();
    aclr = 0;
    vec++;
    if ({obs, act24} !== {expo(), 1'b0}) begin
      miss++; $display("FAIL alarm_clr_wins: got %h want %h", obs, expo());
    end
    goto(6, 59, 59);
    auto_ack = 1;
    one_hz = 1; step();
    en = 0; step();
    vec++;
    if ({obs, act12} !== {expo(), 1'b0}) begin
      miss++; $display("FAIL alarm_en_off: got %h want %h", obs, expo());
    end
    drain();
  endtask

  task automatic test_coalesce();
    int bad;
    drain();
    bad = 0;
    repeat (3) begin
      one_hz = 1; step();
      if (hs !== 4'b1010) bad++;
      step();
      if (hs !== 4'b1010) bad++;
    end
    vec++;
    if (bad !== 0) begin
      miss++; $display("FAIL co_hold: %0d cycles stb low, want 0", bad);
    end
    ack = 1; step();
    vec++;
    if (hs !== 4'b1010) begin
      miss++; $display("FAIL co_pending: got %b want 1010", hs);
    end
    ack = 1; step();
    step();
    vec++;
    if (hs !== 4'b0000) begin
      miss++; $display("FAIL co_done: got %b want 0000", hs);
    end
    one_hz = 1; step();
    one_hz = 1; ack = 1; step();
    vec++;
    if (hs !== 4'b1010) begin
      miss++; $display("FAIL co_coincide: got %b want 1010", hs);
    end
    ack = 1; step();
    vec++;
    if ({obs, hs} !== {expo(), 4'b0000}) begin
      miss++; $display("FAIL co_final: got %h/%b want %h/0000", obs, hs, expo());
    end
  endtask

  task automatic test_reset_mid();
    one_hz = 1; step();
    #2 rst = 1;
    #1 model_reset();
    vec++;
    if ({obs, hs} !== {expo(), 4'b1111}) begin
      miss++; $display("FAIL mid_reset: got %h/%b want %h/1111", obs, hs, expo());
    end
    @(posedge clk); #1;
    rst = 0;
    ack = 1; step();
    vec++;
    if (hs !== 4'b0000) begin
      miss++; $display("FAIL mid_reset_ack: got %b want 0000", hs);
    end
  endtask

  task automatic test_random();
    en = 1;
    goto_alarm((t / 60 + 1) % 1440 / 60, (t / 60 + 1) % 60);
    auto_ack = 1;
    for (int i = 0; i < 600; i++) begin
      one_hz  = ($urandom_range(0, 1) == 0);
      set_stb = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) {set_h, set_m, set_a} = 3'b000;
        else {set_h, set_m, set_a} = 3'($urandom);
      end
      en   = ($urandom_range(0, 15) != 0);
      aclr = ($urandom_range(0, 31) == 0);
      step();
      vec++;
      if (obs !== expo()) begin
        miss++; $display("FAIL rand_%0d: got %h want %h", i, obs, expo());
      end
    end
    {set_h, set_m, set_a, aclr} = 4'b0000;
    en = 0;
    drain();
  endtask

  initial begin
    vec = 0; miss = 0; auto_ack = 0;
    test_reset();
    test_rollover();
    test_twelve();
    test_set();
    test_alarm();
    test_coalesce();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
